tx_frame_sequencer: RTL and testbench

TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

---
 rtl/tx_frame_pkg.sv | 31 +++
 rtl/tx_seq_timer.sv | 29 ++
 rtl/tx_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_pkg.sv
// Shared definitions for the UART frame sequencer: state encoding, frame size
// and the byte-ordering helper used to serialise a latched score frame.
package tx_frame_pkg;

  localparam int FRAME_BYTES = 4;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [1:0]  board_id;
    logic [23:0] points;
  } frame_t;

  // Board identifier goes first, then the score MSB first.
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {6'b0, f.board_id};
      2'd1:    b = f.points[23:16];
      2'd2:    b = f.points[15:8];
      default: b = f.points[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_seq_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare,
// shared between the inter-byte gap and the tx_done timeout.
module tx_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // >= rather than == keeps a terminal of zero from being skipped past.
  assign tc = (count_reg >= terminal);

endmodule

// File: rtl/tx_frame_sequencer.sv
// Sends a 4-byte score frame (board id + 24-bit points) through a byte UART,
// with optional idle gaps between bytes and a per-byte tx_done timeout.
module tx_frame_sequencer
  import tx_frame_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        send,
  input  logic [1:0]  board_ID,
  input  logic [23:0] points,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_err
);

  localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0]    GAP_TC     = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0]    TIMEOUT_TC = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BYTES - 1);

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  frame_t           frame_reg, frame_next;

  logic             tx_start_reg, tx_start_next;
  logic [7:0]       tx_byte_reg, tx_byte_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic             tx_err_reg, tx_err_next;

  logic             timer_clear;
  logic             timer_enable;
  logic [TW-1:0]    timer_terminal;
  logic             timer_tc;

  // The timer restarts on entry to START (so the timeout counts from the
  // tx_start cycle) and on entry to GAP.
  assign timer_clear    = (state_next != state_reg) &&
                          ((state_next == ST_START) || (state_next == ST_GAP));
  assign timer_enable   = (state_reg == ST_START) || (state_reg == ST_WAIT) ||
                          (state_reg == ST_GAP);
  assign timer_terminal = (state_reg == ST_GAP) ? GAP_TC : TIMEOUT_TC;

  tx_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .pclk     (pclk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timer_terminal),
    .tc       (timer_tc)
  );

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    frame_next  = frame_reg;
    tx_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (send) begin
          frame_next = '{board_id: board_ID, points: points};
          idx_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done takes priority over a timeout landing in the same cycle.
        if (tx_done) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
          end
        end else if (timer_tc) begin
          tx_err_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (timer_tc) begin
          state_next = ST_START;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_start_next   = (state_next == ST_START);
    tx_byte_next    = (state_next == ST_START) ? frame_byte(frame_next, idx_next) : tx_byte_reg;
    busy_next       = (state_next != ST_IDLE);
    frame_done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      frame_reg      <= '0;
      tx_start_reg   <= 1'b0;
      tx_byte_reg    <= 8'h00;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      tx_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_reg      <= frame_next;
      tx_start_reg   <= tx_start_next;
      tx_byte_reg    <= tx_byte_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      tx_err_reg     <= tx_err_next;
    end
  end

  assign tx_start   = tx_start_reg;
  assign tx_byte    = tx_byte_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign tx_err     = tx_err_reg;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed scoreboard bench for tx_frame_sequencer: one instance with a 16-clock
// gap and one with no gap, both with a 50-clock tx_done timeout.
module tb_tx_frame_sequencer;

  localparam int GAP_A      = 16;
  localparam int GAP_B      = 0;
  localparam int TIMEOUT    = 50;
  localparam int UART_DELAY = 20;

  logic        pclk = 1'b0;
  logic        rst;
  logic        send_a, send_b;
  logic [1:0]  board_ID;
  logic [23:0] points;
  logic        tx_done;

  logic        a_tx_start, a_busy, a_frame_done, a_tx_err;
  logic [7:0]  a_tx_byte;
  logic        b_tx_start, b_busy, b_frame_done, b_tx_err;
  logic [7:0]  b_tx_byte;

  logic        sel;
  logic        m_tx_start, m_busy, m_frame_done, m_tx_err;
  logic [7:0]  m_tx_byte;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_start, n_fd, n_err;
  int          done_cyc, err_cyc, fd_cyc;
  int          uart_cnt = 0;
  bit          done_valid = 1'b0;
  bit          uart_skip = 1'b0;
  bit          spurious = 1'b0;
  int          start_hist [8];
  logic [7:0]  exp_q [$];

  always #5 pclk = ~pclk;

  tx_frame_sequencer #(.GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TIMEOUT)) dut_a (
    .pclk(pclk), .rst(rst), .send(send_a), .board_ID(board_ID), .points(points),
    .tx_done(tx_done), .tx_start(a_tx_start), .tx_byte(a_tx_byte), .busy(a_busy),
    .frame_done(a_frame_done), .tx_err(a_tx_err)
  );

  tx_frame_sequencer #(.GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(TIMEOUT)) dut_b (
    .pclk(pclk), .rst(rst), .send(send_b), .board_ID(board_ID), .points(points),
    .tx_done(tx_done), .tx_start(b_tx_start), .tx_byte(b_tx_byte), .busy(b_busy),
    .frame_done(b_frame_done), .tx_err(b_tx_err)
  );

  assign m_tx_start   = sel ? b_tx_start   : a_tx_start;
  assign m_tx_byte    = sel ? b_tx_byte    : a_tx_byte;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_tx_err     = sel ? b_tx_err     : a_tx_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_gap();
    return (sel ? GAP_B : GAP_A) + 1;
  endfunction

  task automatic clr_counts();
    n_start = 0;
    n_fd    = 0;
    n_err   = 0;
  endtask

  // One clock: drive this cycle's tx_done from the UART model, then sample
  // the selected DUT's outputs and score them.
  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        tx_done    = 1'b1;
        done_cyc   = cyc;
        done_valid = 1'b1;
      end
    end
    if (m_tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_tx_start", 1, 0);
      else chk("tx_byte", m_tx_byte, exp_q.pop_front());
      if (done_valid) begin
        chk("done_to_start_gap", cyc - done_cyc, exp_gap());
        done_valid = 1'b0;
      end
      if (n_start < 8) start_hist[n_start] = cyc;
      n_start++;
      if (!uart_skip) uart_cnt = UART_DELAY;
      if (spurious) begin
        tx_done  = 1'b1;
        spurious = 1'b0;
      end
    end
    if (m_frame_done) begin
      n_fd++;
      fd_cyc     = cyc;
      done_valid = 1'b0;
    end
    if (m_tx_err) begin
      n_err++;
      err_cyc = cyc;
    end
  endtask

  task automatic push_frame(input logic [1:0] bid, input logic [23:0] pts);
    exp_q.push_back({6'b0, bid});
    exp_q.push_back(pts[23:16]);
    exp_q.push_back(pts[15:8]);
    exp_q.push_back(pts[7:0]);
  endtask

  task automatic send_frame(input logic s, input logic [1:0] bid, input logic [23:0] pts);
    sel        = s;
    board_ID   = bid;
    points     = pts;
    done_valid = 1'b0;
    push_frame(bid, pts);
    if (s) send_b = 1'b1;
    else send_a = 1'b1;
    step();
    send_a = 1'b0;
    send_b = 1'b0;
    chk("start_latency", m_tx_start, 1);
    chk("busy_after_send", m_busy, 1);
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    while (m_busy && i < limit) begin
      step();
      i++;
    end
    chk("idle_within_bound", m_busy, 0);
  endtask

  initial begin
    rst      = 1'b1;
    send_a   = 1'b0;
    send_b   = 1'b0;
    board_ID = 2'b00;
    points   = 24'h0;
    tx_done  = 1'b0;
    sel      = 1'b0;
    clr_counts();

    // Reset values
    step();
    step();
    chk("rst_tx_start", a_tx_start, 0);
    chk("rst_tx_byte", a_tx_byte, 8'h00);
    chk("rst_busy", a_busy, 0);
    chk("rst_frame_done", a_frame_done, 0);
    chk("rst_tx_err", a_tx_err, 0);

    // Normal frame, send on the first clock after reset release
    rst = 1'b0;
    send_frame(1'b0, 2'b10, 24'hA1B2C3);
    wait_idle(300);
    chk("t1_starts", n_start, 4);
    chk("t1_frame_done", n_fd, 1);
    chk("t1_no_err", n_err, 0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Zero-gap instance
    clr_counts();
    send_frame(1'b1, 2'b01, 24'h123456);
    wait_idle(300);
    chk("t2_starts", n_start, 4);
    chk("t2_frame_done", n_fd, 1);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Timeout on first byte, then a clean restart
    sel = 1'b0;
    uart_skip = 1'b1;
    clr_counts();
    send_frame(1'b0, 2'b11, 24'h0F0E0D);
    wait_idle(200);
    chk("t3_err_with_busy_low", m_tx_err, 1);
    chk("t3_err_count", n_err, 1);
    chk("t3_err_latency", err_cyc - start_hist[0], TIMEOUT);
    chk("t3_no_frame_done", n_fd, 0);
    chk("t3_one_start", n_start, 1);
    chk("t3_dropped_bytes", exp_q.size(), 3);
    exp_q.delete();
    uart_skip = 1'b0;
    step();
    chk("t3_err_one_cycle", m_tx_err, 0);
    clr_counts();
    send_frame(1'b0, 2'b10, 24'hA1B2C3);
    wait_idle(300);
    chk("t3_restart_starts", n_start, 4);
    chk("t3_restart_done", n_fd, 1);

    // send held high, inputs changed mid-frame
    clr_counts();
    sel        = 1'b0;
    board_ID   = 2'b10;
    points     = 24'hA1B2C3;
    done_valid = 1'b0;
    push_frame(2'b10, 24'hA1B2C3);
    send_a = 1'b1;
    step();
    repeat (30) step();
    points = 24'h000001;
    push_frame(2'b10, 24'h000001);
    begin
      int i = 0;
      while (n_start < 5 && i < 400) begin
        step();
        i++;
      end
    end
    send_a = 1'b0;
    chk("t4_second_started", n_start, 5);
    chk("t4_first_done_before", n_fd, 1);
    chk("t4_second_after_idle", start_hist[4] - fd_cyc, 2);
    wait_idle(300);
    chk("t4_total_starts", n_start, 8);
    chk("t4_total_done", n_fd, 2);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Reset during WAIT of the third byte
    clr_counts();
    send_frame(1'b0, 2'b10, 24'hA1B2C3);
    begin
      int i = 0;
      while (n_start < 3 && i < 200) begin
        step();
        i++;
      end
    end
    repeat (5) step();
    chk("t5_busy_before_rst", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_start", a_tx_start, 0);
    chk("t5_rst_tx_byte", a_tx_byte, 8'h00);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_frame_done", a_frame_done, 0);
    chk("t5_rst_tx_err", a_tx_err, 0);
    uart_cnt   = 0;
    done_valid = 1'b0;
    chk("t5_dropped_bytes", exp_q.size(), 1);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    clr_counts();
    repeat (40) step();
    chk("t5_no_start_after_rst", n_start, 0);
    chk("t5_idle_after_rst", a_busy, 0);

    // Spurious tx_done during START
    clr_counts();
    spurious = 1'b1;
    send_frame(1'b0, 2'b01, 24'h445566);
    wait_idle(400);
    chk("t6_spurious_ignored", start_hist[1] - start_hist[0], UART_DELAY + GAP_A + 1);
    chk("t6_starts", n_start, 4);
    chk("t6_frame_done", n_fd, 1);
    chk("t6_no_err", n_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
